// File: rtl/pipelined_adder.sv
// Pipelined W-bit add/subtract: carry chain split into STAGES chunks, one register per chunk.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int unsigned W      = 256,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned C = W / STAGES;

    generate
        if (STAGES < 1 || (W % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_adder: W must be a multiple of STAGES (STAGES >= 1)");
        end
    endgenerate

    logic              adv;
    logic [W-1:0]      a_q [STAGES];
    logic [W-1:0]      b_q [STAGES];
    logic [W-1:0]      s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic [C:0]        add_res [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Register j holds operands after chunk j-1 is done; chunk j is added from it.
    genvar j;
    generate
        for (j = 0; j < STAGES; j++) begin : g_chunk
            assign add_res[j] = {1'b0, a_q[j][j*C +: C]} + {1'b0, b_q[j][j*C +: C]}
                              + (C+1)'(c_q[j]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q       <= '0;
            v_q       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            a_q[0] <= a;
            b_q[0] <= sub ? ~b : b;
            s_q[0] <= '0;
            c_q[0] <= sub | cin;
            v_q[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_q[k]                 <= a_q[k-1];
                b_q[k]                 <= b_q[k-1];
                s_q[k]                 <= s_q[k-1];
                s_q[k][(k-1)*C +: C]   <= add_res[k-1][C-1:0];
                c_q[k]                 <= add_res[k-1][C];
                v_q[k]                 <= v_q[k-1];
            end
            out_valid                  <= v_q[STAGES-1];
            sum                        <= s_q[STAGES-1];
            sum[(STAGES-1)*C +: C]     <= add_res[STAGES-1][C-1:0];
            cout                       <= add_res[STAGES-1][C];
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic msb_carry_in;

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_carry_in = a_q[STAGES-1][W-1] ^ b_q[STAGES-1][W-1] ^ add_res[STAGES-1][C-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= msb_carry_in ^ add_res[STAGES-1][C];
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks of pipelined_adder at (256,4), (8,1) and (64,8).
module tb_pipelined_adder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] a, b;
    logic         cin, sub, out_ready;
    int           sel;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic         iv0, iv1, iv2, or0, or1, or2;
    logic         ir0, ir1, ir2, ov0, ov1, ov2;
    logic         co0, co1, co2, of0, of1, of2;
    logic [255:0] s0;
    logic [7:0]   s1;
    logic [63:0]  s2;

    logic         obs_in_ready, obs_out_valid, obs_cout, obs_ovf;
    logic [255:0] obs_sum;

    always #5 clk = ~clk;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);
    assign or0 = (sel == 0) ? out_ready : 1'b1;
    assign or1 = (sel == 1) ? out_ready : 1'b1;
    assign or2 = (sel == 2) ? out_ready : 1'b1;

    pipelined_adder #(.W(256), .STAGES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(of0)
    );
    pipelined_adder #(.W(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );
    pipelined_adder #(.W(64), .STAGES(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a[63:0]), .b(b[63:0]),
        .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(of2)
    );

    always_comb begin
        obs_in_ready  = ir0;
        obs_out_valid = ov0;
        obs_sum       = s0;
        obs_cout      = co0;
        obs_ovf       = of0;
        if (sel == 1) begin
            obs_in_ready  = ir1;
            obs_out_valid = ov1;
            obs_sum       = {248'b0, s1};
            obs_cout      = co1;
            obs_ovf       = of1;
        end else if (sel == 2) begin
            obs_in_ready  = ir2;
            obs_out_valid = ov2;
            obs_sum       = {192'b0, s2};
            obs_cout      = co2;
            obs_ovf       = of2;
        end
    end

    function automatic int unsigned width_of(input int s);
        return (s == 1) ? 8 : (s == 2) ? 64 : 256;
    endfunction

    function automatic int unsigned stages_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 8 : 4;
    endfunction

    // Reference result {ovf, cout, sum} for a w-bit operation.
    function automatic logic [257:0] model(input logic [255:0] ma, input logic [255:0] mb,
                                           input logic mcin, input logic msub,
                                           input int unsigned w);
        logic [255:0] mask, am, bm, s;
        logic [256:0] ext;
        logic         c, ov;
        mask = (w == 256) ? '1 : ((256'd1 << w) - 256'd1);
        am   = ma & mask;
        bm   = (msub ? ~mb : mb) & mask;
        c    = msub ? 1'b1 : mcin;
        ext  = {1'b0, am} + {1'b0, bm} + 257'(c);
        s    = ext[255:0] & mask;
`ifdef PIPELINED_ADDER_OVF_EN
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
`else
        ov   = 1'b0;
`endif
        return {ov, ext[w], s};
    endfunction

    // Issues one operation unstalled; lat counts posedges with the accepting edge as 1.
    task automatic run_one(input logic [255:0] ta, input logic [255:0] tb_, input logic tcin,
                           input logic tsub, output logic [255:0] rs, output logic rc,
                           output logic ro, output int lat);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!obs_out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = obs_sum; rc = obs_cout; ro = obs_ovf;
    endtask

    task automatic test_reset;
        logic [255:0] exp_sum;
        logic         stale;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({obs_out_valid, obs_cout, obs_ovf, obs_in_ready} !== 4'b0001 || obs_sum !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v/c/o/rdy=%b sum=%h expected 0001 sum=0",
                     {obs_out_valid, obs_cout, obs_ovf, obs_in_ready}, obs_sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill the pipe against a stalled consumer so several ops are in flight.
        a = '1; b = '1; out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 20 && !obs_out_valid; i++) @(negedge clk);
        exp_sum = '1;
        exp_sum[0] = 1'b0;
        vectors++;
        if (obs_out_valid !== 1'b1 || obs_sum !== exp_sum || obs_cout !== 1'b1 || obs_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_fill: got v=%b rdy=%b c=%b sum=%h expected v=1 rdy=0 c=1 sum=%h",
                     obs_out_valid, obs_in_ready, obs_cout, obs_sum, exp_sum);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({obs_out_valid, obs_cout, obs_ovf, obs_in_ready} !== 4'b0001 || obs_sum !== '0) begin
            miscompares++;
            $display("FAIL reset_midstream: got v/c/o/rdy=%b sum=%h expected 0001 sum=0",
                     {obs_out_valid, obs_cout, obs_ovf, obs_in_ready}, obs_sum);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) stale = 1'b1;
        end
        vectors++;
        if (stale) begin
            miscompares++;
            $display("FAIL no_stale: got a valid result or in_ready=0 after reset, required none");
        end
    endtask

    task automatic test_full_carry;
        logic [255:0] rs;
        logic rc, ro;
        int lat;
        sel = 0;
        run_one('1, '0, 1'b1, 1'b0, rs, rc, ro, lat);
        vectors++;
        if (rs !== '0 || rc !== 1'b1 || ro !== 1'b0 || lat != 5) begin
            miscompares++;
            $display("FAIL full_carry: got sum=%h c=%b o=%b lat=%0d expected sum=0 c=1 o=0 lat=5",
                     rs, rc, ro, lat);
        end
    endtask

    task automatic test_subtract;
        logic [255:0] rs, exp_sum;
        logic rc, ro;
        int lat;
        sel = 0;
        exp_sum = '1;
        exp_sum[0] = 1'b0;
        run_one(256'd5, 256'd7, 1'b1, 1'b1, rs, rc, ro, lat);
        vectors++;
        if (rs !== exp_sum || rc !== 1'b0 || ro !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_5_7: got sum=%h c=%b o=%b expected sum=%h c=0 o=0", rs, rc, ro, exp_sum);
        end
        run_one(256'd7, 256'd5, 1'b0, 1'b1, rs, rc, ro, lat);
        vectors++;
        if (rs !== 256'd2 || rc !== 1'b1 || ro !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_7_5: got sum=%h c=%b o=%b expected sum=2 c=1 o=0", rs, rc, ro);
        end
    endtask

    task automatic test_overflow;
        logic [255:0] rs, ta, exp_sum;
        logic rc, ro, exp_ovf;
        int lat;
        sel = 0;
        ta = '1;
        ta[255] = 1'b0;
        exp_sum = '0;
        exp_sum[255] = 1'b1;
`ifdef PIPELINED_ADDER_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        run_one(ta, 256'd1, 1'b0, 1'b0, rs, rc, ro, lat);
        vectors++;
        if (rs !== exp_sum || rc !== 1'b0 || ro !== exp_ovf) begin
            miscompares++;
            $display("FAIL signed_ovf: got sum=%h c=%b o=%b expected sum=%h c=0 o=%b",
                     rs, rc, ro, exp_sum, exp_ovf);
        end
    endtask

    task automatic test_sweep_latency;
        logic [255:0] rs;
        logic rc, ro;
        int lat;
        sel = 1;
        run_one(256'h00F0, 256'h0020, 1'b0, 1'b0, rs, rc, ro, lat);
        vectors++;
        if (rs !== 256'h10 || rc !== 1'b1 || ro !== 1'b0 || lat != 2) begin
            miscompares++;
            $display("FAIL w8_s1: got sum=%h c=%b o=%b lat=%0d expected sum=10 c=1 o=0 lat=2",
                     rs, rc, ro, lat);
        end
        sel = 2;
        run_one(256'h0123456789ABCDEF, 256'h1111111111111111, 1'b1, 1'b0, rs, rc, ro, lat);
        vectors++;
        if (rs !== 256'h123456789ABCDF01 || rc !== 1'b0 || ro !== 1'b0 || lat != 9) begin
            miscompares++;
            $display("FAIL w64_s8: got sum=%h c=%b o=%b lat=%0d expected sum=123456789abcdf01 c=0 o=0 lat=9",
                     rs, rc, ro, lat);
        end
    endtask

    // Stream n ops into DUT s; rnd randomises in_valid/out_ready, else full rate both sides.
    task automatic test_back_to_back(input int s, input int n, input bit rnd);
        logic [257:0] q[$];
        logic [257:0] held, got, exp;
        logic         hold;
        int           acc, cycles;
        sel = s; acc = 0; cycles = 0; hold = 1'b0; held = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        while ((acc < n || q.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            got = {obs_ovf, obs_cout, obs_sum};
            if (hold) begin
                vectors++;
                if (got !== held || obs_out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold dut%0d: got v=%b %h expected v=1 %h", s, obs_out_valid, got, held);
                end
            end
            in_valid  = (acc < n) && (!rnd || $urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) begin
                a[i*32 +: 32] = $urandom;
                b[i*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) a = '1;
            cin       = 1'($urandom_range(0, 1));
            sub       = ($urandom_range(0, 2) == 0);
            out_ready = !rnd || ($urandom_range(0, 3) != 0);
            #1;
            if (obs_out_valid && !out_ready) begin
                vectors++;
                if (obs_in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_ready dut%0d: got in_ready=%b expected 0", s, obs_in_ready);
                end
            end
            if (obs_out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra dut%0d: got result %h expected none", s, got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL stream_data dut%0d: got %h expected %h", s, got, exp);
                    end
                end
            end
            hold = obs_out_valid && !out_ready;
            held = got;
            if (in_valid && obs_in_ready) begin
                q.push_back(model(a, b, cin, sub, width_of(s)));
                acc++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (acc != n || q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_count dut%0d: got accepted=%0d pending=%0d expected %0d/0 (stages=%0d)",
                     s, acc, q.size(), n, stages_of(s));
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_carry();
        test_subtract();
        test_overflow();
        test_sweep_latency();
        for (int s = 0; s < 3; s++) begin
            test_back_to_back(s, 200, 1'b1);
            test_back_to_back(s, 40, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
